// File: rtl/morse_input_timing.sv
// Front-end timing for the Morse entry/LCD system: push-button debouncer,
// saturating press-duration tick counter and free-running LCD step time base.
module morse_input_timing #(
  parameter int DEB_CNT_W = 16,
  parameter int PRESS_DIV = 50000,
  parameter int LCD_DIV   = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PB,
  output logic        PB_state,
  output logic        PB_down,
  output logic        PB_up,
  input  logic        press_start,
  output logic [16:0] press_ticks,
  input  logic        lcd_start,
  output logic [16:0] lcd_ticks,
  output logic        lcd_strobe
);

  localparam int PRESS_W = (PRESS_DIV > 2) ? $clog2(PRESS_DIV) : 1;
  localparam int LCD_W   = (LCD_DIV > 2) ? $clog2(LCD_DIV) : 1;
  localparam logic [PRESS_W-1:0] PRESS_LAST = PRESS_W'(PRESS_DIV - 1);
  localparam logic [LCD_W-1:0]   LCD_LAST   = LCD_W'(LCD_DIV - 1);
  localparam logic [16:0]        TICK_MAX   = 17'h1FFFF;

  logic                 sync0_q, sync0_d;
  logic                 sync1_q, sync1_d;
  logic                 pb_state_q, pb_state_d;
  logic [DEB_CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic                 deb_idle, deb_cnt_max;

  logic [PRESS_W-1:0]   press_pre_q, press_pre_d;
  logic [16:0]          press_ticks_q, press_ticks_d;

  logic [LCD_W-1:0]     lcd_pre_q, lcd_pre_d;
  logic [16:0]          lcd_ticks_q, lcd_ticks_d;
  logic                 lcd_strobe_q, lcd_strobe_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q       <= 1'b0;
      sync1_q       <= 1'b0;
      pb_state_q    <= 1'b0;
      deb_cnt_q     <= '0;
      press_pre_q   <= '0;
      press_ticks_q <= '0;
      lcd_pre_q     <= '0;
      lcd_ticks_q   <= '0;
      lcd_strobe_q  <= 1'b0;
    end else begin
      sync0_q       <= sync0_d;
      sync1_q       <= sync1_d;
      pb_state_q    <= pb_state_d;
      deb_cnt_q     <= deb_cnt_d;
      press_pre_q   <= press_pre_d;
      press_ticks_q <= press_ticks_d;
      lcd_pre_q     <= lcd_pre_d;
      lcd_ticks_q   <= lcd_ticks_d;
      lcd_strobe_q  <= lcd_strobe_d;
    end
  end

  // Button is active-low; the synchronizer stores "pressed" as 1.
  always_comb begin
    sync0_d     = ~PB;
    sync1_d     = sync0_q;
    deb_idle    = (pb_state_q == sync1_q);
    deb_cnt_max = &deb_cnt_q;
    deb_cnt_d   = deb_idle ? '0 : deb_cnt_q + DEB_CNT_W'(1);
    pb_state_d  = (!deb_idle && deb_cnt_max) ? ~pb_state_q : pb_state_q;
  end

  always_comb begin
    press_pre_d   = press_pre_q;
    press_ticks_d = press_ticks_q;
    if (!press_start) begin
      press_pre_d   = '0;
      press_ticks_d = '0;
    end else if (press_pre_q == PRESS_LAST) begin
      press_pre_d = '0;
      if (press_ticks_q != TICK_MAX)
        press_ticks_d = press_ticks_q + 17'd1;
    end else begin
      press_pre_d = press_pre_q + PRESS_W'(1);
    end
  end

  // Stopped time base holds both prescaler and tick count so it resumes in phase.
  always_comb begin
    lcd_pre_d    = lcd_pre_q;
    lcd_ticks_d  = lcd_ticks_q;
    lcd_strobe_d = 1'b0;
    if (lcd_start) begin
      if (lcd_pre_q == LCD_LAST) begin
        lcd_pre_d    = '0;
        lcd_ticks_d  = lcd_ticks_q + 17'd1;
        lcd_strobe_d = 1'b1;
      end else begin
        lcd_pre_d = lcd_pre_q + LCD_W'(1);
      end
    end
  end

  assign PB_state    = pb_state_q;
  assign PB_down     = ~deb_idle & deb_cnt_max & ~pb_state_q;
  assign PB_up       = ~deb_idle & deb_cnt_max & pb_state_q;
  assign press_ticks = press_ticks_q;
  assign lcd_ticks   = lcd_ticks_q;
  assign lcd_strobe  = lcd_strobe_q;

endmodule

// File: tb/tb_morse_input_timing.sv
// Directed bench for morse_input_timing with small divisors; every check is an
// immediate assertion against a hand-derived value.
module tb_morse_input_timing;

  logic        clk;
  logic        rst_n;
  logic        PB;
  logic        PB_state;
  logic        PB_down;
  logic        PB_up;
  logic        press_start;
  logic [16:0] press_ticks;
  logic        lcd_start;
  logic [16:0] lcd_ticks;
  logic        lcd_strobe;

  int n_assert;
  int n_fail;
  int strobe_cnt;

  morse_input_timing #(
    .DEB_CNT_W(4),
    .PRESS_DIV(4),
    .LCD_DIV  (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .PB         (PB),
    .PB_state   (PB_state),
    .PB_down    (PB_down),
    .PB_up      (PB_up),
    .press_start(press_start),
    .press_ticks(press_ticks),
    .lcd_start  (lcd_start),
    .lcd_ticks  (lcd_ticks),
    .lcd_strobe (lcd_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pb_state"}, {16'd0, PB_state}, 17'd0);
    check({tag, "_pb_down"}, {16'd0, PB_down}, 17'd0);
    check({tag, "_pb_up"}, {16'd0, PB_up}, 17'd0);
    check({tag, "_press_ticks"}, press_ticks, 17'd0);
    check({tag, "_lcd_ticks"}, lcd_ticks, 17'd0);
    check({tag, "_lcd_strobe"}, {16'd0, lcd_strobe}, 17'd0);
  endtask

  // Inputs change and outputs are sampled on the falling edge; edge i is the
  // i-th rising edge after the inputs were applied.
  task automatic expect_press_accept(input string tag);
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      check({tag, "_down"}, {16'd0, PB_down}, (i == 17) ? 17'd1 : 17'd0);
      check({tag, "_up"}, {16'd0, PB_up}, 17'd0);
      check({tag, "_state"}, {16'd0, PB_state}, (i == 18) ? 17'd1 : 17'd0);
    end
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    PB          = 1'b0;
    press_start = 1'b1;
    lcd_start   = 1'b1;

    // Reset with button held and both time bases enabled
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    expect_press_accept("accept");

    // Release of the held button
    PB = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      check("release_up", {16'd0, PB_up}, (i == 17) ? 17'd1 : 17'd0);
      check("release_down", {16'd0, PB_down}, 17'd0);
      check("release_state", {16'd0, PB_state}, (i == 18) ? 17'd0 : 17'd1);
    end

    // Bouncing press: 10 low, 1 high, then stable low
    PB = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      if (i == 11) PB = 1'b1;
      @(negedge clk);
      check("bounce_down", {16'd0, PB_down}, 17'd0);
      check("bounce_state", {16'd0, PB_state}, 17'd0);
    end
    PB = 1'b0;
    expect_press_accept("settle");

    // Asynchronous reset mid-operation, then re-acceptance of the held button
    press_start = 1'b0;
    lcd_start   = 1'b0;
    #3 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    expect_press_accept("reaccept");
    check("indep_press", press_ticks, 17'd0);
    check("indep_lcd", lcd_ticks, 17'd0);

    // Press counter: one tick every 4 clocks
    press_start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      check("press_count", press_ticks, 17'(i / 4));
    end
    check("press_after20", press_ticks, 17'd5);
    press_start = 1'b0;
    @(negedge clk);
    check("press_clear", press_ticks, 17'd0);

    // Partial period discarded when press_start drops
    press_start = 1'b1;
    repeat (3) @(negedge clk);
    press_start = 1'b0;
    @(negedge clk);
    press_start = 1'b1;
    repeat (3) @(negedge clk);
    check("press_partial", press_ticks, 17'd0);
    @(negedge clk);
    check("press_partial_first", press_ticks, 17'd1);
    press_start = 1'b0;
    @(negedge clk);

    // Saturation: preload just below the top, prescaler is at 0
    press_start = 1'b1;
    dut.press_ticks_q = 17'd131069;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 4) check("press_sat_70", press_ticks, 17'd131070);
      if (i == 8) check("press_sat_71", press_ticks, 17'd131071);
      if (i == 16) check("press_sat_hold", press_ticks, 17'd131071);
    end
    press_start = 1'b0;

    // LCD counter: one tick every 3 clocks with a strobe after each update
    strobe_cnt = 0;
    lcd_start  = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      check("lcd_count", lcd_ticks, 17'(i / 3));
      check("lcd_strobe", {16'd0, lcd_strobe}, (i % 3 == 0) ? 17'd1 : 17'd0);
      if (lcd_strobe) strobe_cnt++;
    end
    check("lcd_strobe_total", 17'(strobe_cnt), 17'd3);
    lcd_start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      check("lcd_hold", lcd_ticks, 17'd3);
      check("lcd_hold_strobe", {16'd0, lcd_strobe}, 17'd0);
    end

    // LCD wrap from the top value
    dut.lcd_ticks_q = 17'd131071;
    @(negedge clk);
    check("lcd_preload_held", lcd_ticks, 17'd131071);
    lcd_start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("lcd_wrap_ticks", lcd_ticks, (i >= 3) ? 17'd0 : 17'd131071);
      check("lcd_wrap_strobe", {16'd0, lcd_strobe}, (i == 3) ? 17'd1 : 17'd0);
    end
    lcd_start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_input_timing.md
Name: morse_input_timing

Overview:
- Front-end timing block for the Morse entry/LCD system; one instance per push-button plus shared time bases.
- Contains three sub-functions:
  - a push-button debouncer producing a level and one-cycle press/release strobes;
  - a press-duration tick counter, started and cleared by the top level, that it compares against short/long/gap thresholds;
  - a free-running LCD step tick counter with a change strobe, which sequences the HD44780 state machine.

Parameters:
- DEB_CNT_W, 16, debounce counter width; input must be stable 2^DEB_CNT_W clocks before it is accepted.
- PRESS_DIV, 50000, clk cycles per press tick (1 ms at 50 MHz).
- LCD_DIV, 100000, clk cycles per LCD tick (2 ms at 50 MHz).

Ports:
- clk, input, 1, system clock; all logic rising-edge.
- rst_n, input, 1, asynchronous active-low reset.
- PB, input, 1, raw push-button; asynchronous, glitchy, active-low (0 = pressed).
- PB_state, output, 1, debounced level; 1 while the button is held down.
- PB_down, output, 1, one-cycle strobe on accepted press.
- PB_up, output, 1, one-cycle strobe on accepted release.
- press_start, input, 1, 1 = count press ticks; 0 = clear.
- press_ticks, output, 17, press tick count; saturating.
- lcd_start, input, 1, 1 = LCD time base runs; 0 = frozen.
- lcd_ticks, output, 17, LCD tick count; wraps.
- lcd_strobe, output, 1, one-cycle pulse in the cycle after lcd_ticks changes.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - sync regs = 0 (released), PB_state = 0, debounce counter = 0;
  - both prescalers = 0, press_ticks = 0, lcd_ticks = 0, lcd_strobe = 0.
- Debouncer:
  - Synchronizer: two flops; sync0 <= ~PB, sync1 <= sync0.
  - idle = (PB_state == sync1).
  - Counter behaviour:
    - idle: counter <= 0;
    - otherwise counter <= counter + 1;
    - when counter is all-ones and not idle: PB_state <= ~PB_state and counter wraps to 0.
  - Strobes are combinational, each high exactly the one cycle before PB_state flips:
    - PB_down = ~idle & cnt_max & ~PB_state;
    - PB_up = ~idle & cnt_max & PB_state.
  - Latency: PB settles at edge 0 -> strobe high between edges 2^DEB_CNT_W+1 and 2^DEB_CNT_W+2 -> PB_state toggles at edge 2^DEB_CNT_W+2.
  - Any bounce back to the idle level before cnt_max restarts the count from 0.
  - PB_down and PB_up are never high simultaneously.
- Press counter:
  - press_start = 0: prescaler <= 0, press_ticks <= 0 (synchronous clear).
  - press_start = 1: prescaler increments; at PRESS_DIV-1 it returns to 0 and press_ticks increments.
  - First increment is visible PRESS_DIV clocks after press_start rises.
  - Saturates at 131071; never wraps.
  - Deasserting press_start mid-period discards the partial count.
- LCD counter:
  - lcd_start = 1: same prescaler scheme with LCD_DIV; lcd_ticks wraps 131071 -> 0.
  - lcd_strobe = 1 for exactly one cycle following every lcd_ticks update, including the wrap.
  - lcd_start = 0: prescaler and lcd_ticks hold their values; lcd_strobe = 0.
  - Counting resumes from the held values when lcd_start returns to 1.
- Independence: all three functions share only clk and rst_n; no cross-coupling.
- Reset mid-operation: all state returns to reset values immediately; a held button is re-accepted via the normal debounce latency after release of reset.
- Divisor parameters must be >= 2.

Test Plan (DEB_CNT_W=4, PRESS_DIV=4, LCD_DIV=3):
1. Reset: rst_n = 0 with PB = 0 and both starts = 1. Required: all outputs 0. Release rst_n, then PB_down high for 1 cycle at edge 17 -> 18 and PB_state = 1 from edge 18.
2. Bounce: PB goes low for 10 clocks, high for 1 clock, then low stable. Required: no strobe during the bounce; PB_down occurs 17 edges after the final settle.
3. Release: held button, set PB = 1. Required: PB_up one cycle, then PB_state = 0; PB_down stays 0 throughout.
4. Press counter: press_start = 1 for 20 clocks. Required: press_ticks = 5. Drop press_start -> press_ticks = 0 next cycle. Force a long run: press_ticks stops at 131071.
5. LCD counter: lcd_start = 1 for 9 clocks. Required: lcd_ticks = 3 with 3 single-cycle lcd_strobe pulses. lcd_start = 0 for 10 clocks: value held, no strobes.
6. LCD wrap: preload by running to 131071, then one more period. Required: lcd_ticks = 0 and lcd_strobe = 1 for one cycle.
